// File: rtl/hazard_forward_unit_pkg.sv
// hazard_forward_unit_pkg
//   Shared constants for the hazard/forwarding unit: the "no forward"
//   select code and the bit layout of one scoreboard entry.
//   Entry layout, LSB first: valid, regwrite, memread, rd[AWIDTH-1:0].
package hazard_forward_unit_pkg;

  localparam int FWD_REGFILE = 0;

  localparam int VALID_W    = 1;
  localparam int REGWRITE_W = 1;
  localparam int MEMREAD_W  = 1;

  localparam int VALID_BIT    = 0;
  localparam int REGWRITE_BIT = VALID_BIT + VALID_W;
  localparam int MEMREAD_BIT  = REGWRITE_BIT + REGWRITE_W;
  localparam int RD_LSB       = MEMREAD_BIT + MEMREAD_W;

  function automatic int entry_width(input int awidth);
    return awidth + VALID_W + REGWRITE_W + MEMREAD_W;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if
//   Decode-side request and hazard-unit response bundle.
//   master : decode/pipeline side (drives hz_i_*, receives hz_o_*)
//   slave  : hazard_forward_unit  (receives hz_i_*, drives hz_o_*)
interface hazard_forward_unit_if #(
  parameter int AWIDTH    = 5,
  parameter int STAGES    = 3,
  parameter int CNT_WIDTH = 16
) ();
  localparam int FSEL_W = $clog2(STAGES + 1);

  logic                 hz_i_ce;
  logic [AWIDTH-1:0]    hz_i_rs;
  logic [AWIDTH-1:0]    hz_i_rt;
  logic                 hz_i_use_rs;
  logic                 hz_i_use_rt;
  logic [AWIDTH-1:0]    hz_i_rd;
  logic                 hz_i_regwrite;
  logic                 hz_i_memread;
  logic                 hz_i_change_pc;
  logic                 hz_i_hold;
  logic [FSEL_W-1:0]    hz_o_fwd_rs;
  logic [FSEL_W-1:0]    hz_o_fwd_rt;
  logic                 hz_o_stall;
  logic                 hz_o_flush;
  logic [CNT_WIDTH-1:0] hz_o_stall_cnt;

  modport master (
    output hz_i_ce, hz_i_rs, hz_i_rt, hz_i_use_rs, hz_i_use_rt, hz_i_rd,
           hz_i_regwrite, hz_i_memread, hz_i_change_pc, hz_i_hold,
    input  hz_o_fwd_rs, hz_o_fwd_rt, hz_o_stall, hz_o_flush, hz_o_stall_cnt
  );

  modport slave (
    input  hz_i_ce, hz_i_rs, hz_i_rt, hz_i_use_rs, hz_i_use_rt, hz_i_rd,
           hz_i_regwrite, hz_i_memread, hz_i_change_pc, hz_i_hold,
    output hz_o_fwd_rs, hz_o_fwd_rt, hz_o_stall, hz_o_flush, hz_o_stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   STAGES-deep shift register of in-flight destination records.
//   Entry 0 is EX, entry STAGES-1 is WB; the WB record falls off the end.
// Ports:
//   clk_sys   clock, rising edge
//   rst_b     synchronous active-low reset, clears every entry
//   hold      freeze all entries
//   bubble    load an invalid record into entry 0 instead of the decode fields
//   rd, regwrite, memread   decode fields for entry 0
//   entries   flattened entries, entry i at [i*EW +: EW]
module hazard_scoreboard
  import hazard_forward_unit_pkg::*;
#(
  parameter int AWIDTH = 5,
  parameter int STAGES = 3,
  localparam int EW    = entry_width(AWIDTH)
) (
  input  logic                 clk_sys,
  input  logic                 rst_b,
  input  logic                 hold,
  input  logic                 bubble,
  input  logic [AWIDTH-1:0]    rd,
  input  logic                 regwrite,
  input  logic                 memread,
  output logic [STAGES*EW-1:0] entries
);

  logic [EW-1:0] ent [STAGES];

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      for (int i = 0; i < STAGES; i++) ent[i] <= '0;
    end else if (!hold) begin
      ent[0] <= bubble ? '0 : {rd, memread, regwrite, 1'b1};
      for (int i = 1; i < STAGES; i++) ent[i] <= ent[i-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_flat
    assign entries[g*EW +: EW] = ent[g];
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Pipeline hazard and forwarding controller. Tracks destination registers
//   of in-flight instructions, produces operand forward selects, load-use
//   stalls, branch flushes and a saturating stall-cycle counter.
// Ports:
//   hz_clk    clock, rising edge
//   hz_rst    synchronous active-low reset
//   hz_if     slave modport: decode request in, fwd/stall/flush/count out
//             fwd select: 0 = register file, k = forward from stage k-1
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int AWIDTH     = 5,
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 1,
  parameter int CNT_WIDTH  = 16,
  localparam int FSEL_W    = $clog2(STAGES + 1),
  localparam int EW        = entry_width(AWIDTH)
) (
  input  logic                   hz_clk,
  input  logic                   hz_rst,
  hazard_forward_unit_if.slave   hz_if
);

  logic [STAGES*EW-1:0] ent_flat;
  logic [STAGES-1:0]    e_valid;
  logic [STAGES-1:0]    e_rw;
  logic [STAGES-1:0]    e_mr;
  logic [AWIDTH-1:0]    e_rd [STAGES];
  logic [STAGES-1:0]    hit_rs;
  logic [STAGES-1:0]    hit_rt;

  logic [FSEL_W-1:0]    sel_rs;
  logic [FSEL_W-1:0]    sel_rt;
  logic                 load_rs;
  logic                 load_rt;
  logic                 stall_lu;
  logic                 flush_raw;
  logic                 bubble;
  logic [CNT_WIDTH-1:0] cnt;

  for (genvar g = 0; g < STAGES; g++) begin : g_fields
    assign e_valid[g] = ent_flat[g*EW + VALID_BIT];
    assign e_rw[g]    = ent_flat[g*EW + REGWRITE_BIT];
    assign e_mr[g]    = ent_flat[g*EW + MEMREAD_BIT];
    assign e_rd[g]    = ent_flat[g*EW + RD_LSB +: AWIDTH];
    // $0 is hardwired, so a "write" to it never produces a forwardable value
    assign hit_rs[g]  = e_valid[g] & e_rw[g] & (e_rd[g] == hz_if.hz_i_rs) &
                        (e_rd[g] != '0) & hz_if.hz_i_use_rs & hz_if.hz_i_ce;
    assign hit_rt[g]  = e_valid[g] & e_rw[g] & (e_rd[g] == hz_if.hz_i_rt) &
                        (e_rd[g] != '0) & hz_if.hz_i_use_rt & hz_if.hz_i_ce;
  end

  // Scan oldest to youngest so the youngest (lowest index) match is left last.
  // Only the youngest match decides the stall: an older load is shadowed.
  always_comb begin
    sel_rs  = FSEL_W'(FWD_REGFILE);
    sel_rt  = FSEL_W'(FWD_REGFILE);
    load_rs = 1'b0;
    load_rt = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (hit_rs[i]) begin
        sel_rs  = FSEL_W'(i + 1);
        load_rs = e_mr[i] && (i < LOAD_STAGE);
      end
      if (hit_rt[i]) begin
        sel_rt  = FSEL_W'(i + 1);
        load_rt = e_mr[i] && (i < LOAD_STAGE);
      end
    end
  end

  assign stall_lu  = load_rs | load_rt;
  assign flush_raw = hz_if.hz_i_change_pc & ~hz_if.hz_i_hold;
  assign bubble    = flush_raw | stall_lu | ~hz_if.hz_i_ce;

  always_comb begin
    hz_if.hz_o_fwd_rs = '0;
    hz_if.hz_o_fwd_rt = '0;
    hz_if.hz_o_stall  = 1'b0;
    hz_if.hz_o_flush  = 1'b0;
    if (hz_rst) begin
      hz_if.hz_o_fwd_rs = sel_rs;
      hz_if.hz_o_fwd_rt = sel_rt;
      hz_if.hz_o_stall  = hz_if.hz_i_hold | (stall_lu & ~flush_raw);
      hz_if.hz_o_flush  = flush_raw;
    end
  end

  hazard_scoreboard #(
    .AWIDTH (AWIDTH),
    .STAGES (STAGES)
  ) u_scoreboard (
    .clk_sys  (hz_clk),
    .rst_b    (hz_rst),
    .hold     (hz_if.hz_i_hold),
    .bubble   (bubble),
    .rd       (hz_if.hz_i_rd),
    .regwrite (hz_if.hz_i_regwrite),
    .memread  (hz_if.hz_i_memread),
    .entries  (ent_flat)
  );

  // Counts only real load-use bubbles: a flush cancels the stall and a hold
  // is an external freeze, neither is a hazard cycle.
  always_ff @(posedge hz_clk) begin
    if (!hz_rst) begin
      cnt <= '0;
    end else if (stall_lu && !flush_raw && !hz_if.hz_i_hold &&
                 (cnt != {CNT_WIDTH{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hz_if.hz_o_stall_cnt = cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  logic hz_clk = 1'b0;
  logic hz_rst;

  always #5 hz_clk = ~hz_clk;

  // dut_a: defaults (LOAD_STAGE=1, 16-bit counter)
  // dut_b: LOAD_STAGE=2, 2-bit counter (latency and saturation cases)
  hazard_forward_unit_if #(.AWIDTH(5), .STAGES(3), .CNT_WIDTH(16)) if_a ();
  hazard_forward_unit_if #(.AWIDTH(5), .STAGES(3), .CNT_WIDTH(2))  if_b ();

  hazard_forward_unit #(.AWIDTH(5), .STAGES(3), .LOAD_STAGE(1), .CNT_WIDTH(16)) dut_a (
    .hz_clk (hz_clk),
    .hz_rst (hz_rst),
    .hz_if  (if_a)
  );

  hazard_forward_unit #(.AWIDTH(5), .STAGES(3), .LOAD_STAGE(2), .CNT_WIDTH(2)) dut_b (
    .hz_clk (hz_clk),
    .hz_rst (hz_rst),
    .hz_if  (if_b)
  );

  typedef struct {
    int    dut;
    string name;
    bit    stall;
    bit    flush;
    int    cnt;
    bit    chk_fwd;
    int    fwd_rs;
    int    fwd_rt;
  } exp_t;

  exp_t q[$];
  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Monitor: every negedge, compare all expectations queued for this cycle.
  always @(negedge hz_clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] a_rs, a_rt, a_st, a_fl, a_cnt;
      e = q.pop_front();
      if (e.dut == 0) begin
        a_rs = 32'(if_a.hz_o_fwd_rs); a_rt = 32'(if_a.hz_o_fwd_rt);
        a_st = 32'(if_a.hz_o_stall);  a_fl = 32'(if_a.hz_o_flush);
        a_cnt = 32'(if_a.hz_o_stall_cnt);
      end else begin
        a_rs = 32'(if_b.hz_o_fwd_rs); a_rt = 32'(if_b.hz_o_fwd_rt);
        a_st = 32'(if_b.hz_o_stall);  a_fl = 32'(if_b.hz_o_flush);
        a_cnt = 32'(if_b.hz_o_stall_cnt);
      end
      chk($sformatf("%s/%0d stall", e.name, e.dut), a_st, 32'(e.stall));
      chk($sformatf("%s/%0d flush", e.name, e.dut), a_fl, 32'(e.flush));
      chk($sformatf("%s/%0d cnt", e.name, e.dut), a_cnt, 32'(e.cnt));
      if (e.chk_fwd) begin
        chk($sformatf("%s/%0d fwd_rs", e.name, e.dut), a_rs, 32'(e.fwd_rs));
        chk($sformatf("%s/%0d fwd_rt", e.name, e.dut), a_rt, 32'(e.fwd_rt));
      end
    end
  end

  task automatic drv(input bit ce, input int rs, input int rt, input bit urs, input bit urt,
                     input int rd, input bit rw, input bit mr, input bit cpc, input bit hold);
    if_a.hz_i_ce = ce;          if_b.hz_i_ce = ce;
    if_a.hz_i_rs = 5'(rs);      if_b.hz_i_rs = 5'(rs);
    if_a.hz_i_rt = 5'(rt);      if_b.hz_i_rt = 5'(rt);
    if_a.hz_i_use_rs = urs;     if_b.hz_i_use_rs = urs;
    if_a.hz_i_use_rt = urt;     if_b.hz_i_use_rt = urt;
    if_a.hz_i_rd = 5'(rd);      if_b.hz_i_rd = 5'(rd);
    if_a.hz_i_regwrite = rw;    if_b.hz_i_regwrite = rw;
    if_a.hz_i_memread = mr;     if_b.hz_i_memread = mr;
    if_a.hz_i_change_pc = cpc;  if_b.hz_i_change_pc = cpc;
    if_a.hz_i_hold = hold;      if_b.hz_i_hold = hold;
  endtask

  task automatic expect_out(input int dut, input string nm, input bit stall, input bit flush,
                            input int cnt, input bit cf, input int frs, input int frt);
    exp_t e;
    e.dut = dut; e.name = nm; e.stall = stall; e.flush = flush; e.cnt = cnt;
    e.chk_fwd = cf; e.fwd_rs = frs; e.fwd_rt = frt;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge hz_clk);
    #1;
  endtask

  task automatic do_reset();
    hz_rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    hz_rst = 1'b1;
  endtask

  // Common stimulus shapes
  task automatic lw5();    drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); endtask
  task automatic rd_rt5(); drv(1, 0, 5, 0, 1, 0, 0, 0, 0, 0); endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // 1. Reset with every input active
    hz_rst = 1'b0;
    drv(1, 3, 3, 1, 1, 3, 1, 1, 1, 1);
    tick();
    expect_out(0, "rst", 0, 0, 0, 1, 0, 0);
    expect_out(1, "rst", 0, 0, 0, 1, 0, 0);
    tick();
    hz_rst = 1'b1;
    drv(1, 3, 3, 1, 1, 0, 0, 0, 0, 0);
    expect_out(0, "rst_after", 0, 0, 0, 1, 0, 0);
    expect_out(1, "rst_after", 0, 0, 0, 1, 0, 0);
    tick();

    // 2. Forwarding distance follows the writer down the pipe
    do_reset();
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); expect_out(0, "fw_c1", 0, 0, 0, 1, 0, 0); tick();
    drv(1, 3, 0, 1, 0, 0, 0, 0, 0, 0); expect_out(0, "fw_c2", 0, 0, 0, 1, 1, 0); tick();
    expect_out(0, "fw_c3", 0, 0, 0, 1, 2, 0); tick();
    expect_out(0, "fw_c4", 0, 0, 0, 1, 3, 0); tick();
    expect_out(0, "fw_c5", 0, 0, 0, 1, 0, 0); tick();

    // 3. Load-use: 1 stall on dut_a, 2 stalls on dut_b
    do_reset();
    lw5();
    expect_out(0, "lu_c1", 0, 0, 0, 1, 0, 0);
    expect_out(1, "lu_c1", 0, 0, 0, 1, 0, 0);
    tick();
    drv(1, 6, 5, 1, 1, 6, 1, 0, 0, 0);
    expect_out(0, "lu_c2", 1, 0, 0, 0, 0, 0);
    expect_out(1, "lu_c2", 1, 0, 0, 0, 0, 0);
    tick();
    expect_out(0, "lu_c3", 0, 0, 1, 1, 0, 2);
    expect_out(1, "lu_c3", 1, 0, 1, 0, 0, 0);
    tick();
    expect_out(0, "lu_c4", 0, 0, 1, 1, 1, 3);
    expect_out(1, "lu_c4", 0, 0, 2, 1, 0, 3);
    tick();

    // 4. Priority: youngest writer wins; $0 never forwards or stalls
    do_reset();
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); tick();
    tick();
    drv(1, 7, 7, 1, 1, 0, 0, 0, 0, 0); expect_out(0, "pri_7", 0, 0, 0, 1, 1, 1); tick();
    drv(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); tick();
    drv(1, 0, 0, 1, 1, 0, 0, 0, 0, 0); expect_out(0, "pri_r0", 0, 0, 0, 1, 0, 0); tick();

    // 5a. Flush beats load-use stall; the flushed instruction never lands
    do_reset();
    lw5(); tick();
    drv(1, 0, 5, 0, 1, 9, 1, 0, 1, 0); expect_out(0, "fl_c2", 0, 1, 0, 1, 0, 1); tick();
    drv(1, 9, 0, 1, 0, 0, 0, 0, 0, 0); expect_out(0, "fl_c3", 0, 0, 0, 1, 0, 0); tick();

    // 5b. Hold beats flush; entries and counter frozen
    do_reset();
    lw5(); tick();
    drv(1, 0, 5, 0, 1, 9, 1, 0, 1, 1); expect_out(0, "hd_c2", 1, 0, 0, 0, 0, 0); tick();
    expect_out(0, "hd_c3", 1, 0, 0, 0, 0, 0); tick();
    drv(1, 0, 5, 0, 1, 9, 1, 0, 0, 0); expect_out(0, "hd_c4", 1, 0, 0, 0, 0, 0); tick();
    expect_out(0, "hd_c5", 0, 0, 1, 1, 0, 2); tick();

    // 6. Counter saturation on 2-bit dut_b
    do_reset();
    lw5();    expect_out(1, "sat_c1", 0, 0, 0, 1, 0, 0); tick();
    rd_rt5(); expect_out(1, "sat_c2", 1, 0, 0, 0, 0, 0); tick();
    expect_out(1, "sat_c3", 1, 0, 1, 0, 0, 0); tick();
    expect_out(1, "sat_c4", 0, 0, 2, 1, 0, 3); tick();
    lw5();    expect_out(1, "sat_c5", 0, 0, 2, 1, 0, 0); tick();
    rd_rt5(); expect_out(1, "sat_c6", 1, 0, 2, 0, 0, 0); tick();
    expect_out(1, "sat_c7", 1, 0, 3, 0, 0, 0); tick();
    expect_out(1, "sat_c8", 0, 0, 3, 1, 0, 3); tick();
    lw5();    expect_out(1, "sat_c9", 0, 0, 3, 1, 0, 0); tick();
    rd_rt5(); expect_out(1, "sat_c10", 1, 0, 3, 0, 0, 0); tick();
    expect_out(1, "sat_c11", 1, 0, 3, 0, 0, 0); tick();
    expect_out(1, "sat_c12", 0, 0, 3, 1, 0, 3); tick();

    tick();
    tick();
    if (q.size() != 0) begin
      total++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
